alu: RTL and testbench

- Registered 32-bit integer ALU for the ApexCore RV32I datapath.
- Takes two operands and a one-hot decoded instruction vector from the decode stage.
- Produces one result per clock for execute/writeback, branch resolution and load/store address generation.
- One clock; reset is asynchronous and active-high.

---
 rtl/alu.sv | 142 ++++++++++++++
 tb/tb_alu.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// rtl/alu.sv - registered RV32I integer ALU driven by a one-hot decoded opcode
//
// Purpose: computes one integer result per clock for execute/writeback,
// branch resolution (0/1 outcome) and load/store address generation.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears ALUoutput
//   v1           operand 1 (rs1, or PC for auipc/jal/jalr)
//   v2           operand 2 (rs2 or sign-extended immediate)
//   instructions one-hot decoded opcode, lowest set bit wins
//   ALUoutput    registered result, one cycle after the operands

module alu #(
    parameter int XLEN   = 32,
    parameter int NINSTR = 37
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   v1,
    input  logic [XLEN-1:0]   v2,
    input  logic [NINSTR-1:0] instructions,
    output logic [XLEN-1:0]   ALUoutput
);

    localparam int SELW = 6;

    localparam logic [SELW-1:0] OP_LUI   = 6'd0;
    localparam logic [SELW-1:0] OP_AUIPC = 6'd1;
    localparam logic [SELW-1:0] OP_JAL   = 6'd2;
    localparam logic [SELW-1:0] OP_JALR  = 6'd3;
    localparam logic [SELW-1:0] OP_BEQ   = 6'd4;
    localparam logic [SELW-1:0] OP_BNE   = 6'd5;
    localparam logic [SELW-1:0] OP_BLT   = 6'd6;
    localparam logic [SELW-1:0] OP_BGE   = 6'd7;
    localparam logic [SELW-1:0] OP_BLTU  = 6'd8;
    localparam logic [SELW-1:0] OP_BGEU  = 6'd9;
    localparam logic [SELW-1:0] OP_LB    = 6'd10;
    localparam logic [SELW-1:0] OP_LH    = 6'd11;
    localparam logic [SELW-1:0] OP_LW    = 6'd12;
    localparam logic [SELW-1:0] OP_LBU   = 6'd13;
    localparam logic [SELW-1:0] OP_LHU   = 6'd14;
    localparam logic [SELW-1:0] OP_SB    = 6'd15;
    localparam logic [SELW-1:0] OP_SH    = 6'd16;
    localparam logic [SELW-1:0] OP_SW    = 6'd17;
    localparam logic [SELW-1:0] OP_ADDI  = 6'd18;
    localparam logic [SELW-1:0] OP_SLTI  = 6'd19;
    localparam logic [SELW-1:0] OP_SLTIU = 6'd20;
    localparam logic [SELW-1:0] OP_XORI  = 6'd21;
    localparam logic [SELW-1:0] OP_ORI   = 6'd22;
    localparam logic [SELW-1:0] OP_ANDI  = 6'd23;
    localparam logic [SELW-1:0] OP_SLLI  = 6'd24;
    localparam logic [SELW-1:0] OP_SRLI  = 6'd25;
    localparam logic [SELW-1:0] OP_SRAI  = 6'd26;
    localparam logic [SELW-1:0] OP_ADD   = 6'd27;
    localparam logic [SELW-1:0] OP_SUB   = 6'd28;
    localparam logic [SELW-1:0] OP_SLL   = 6'd29;
    localparam logic [SELW-1:0] OP_SLT   = 6'd30;
    localparam logic [SELW-1:0] OP_SLTU  = 6'd31;
    localparam logic [SELW-1:0] OP_XOR   = 6'd32;
    localparam logic [SELW-1:0] OP_SRL   = 6'd33;
    localparam logic [SELW-1:0] OP_SRA   = 6'd34;
    localparam logic [SELW-1:0] OP_OR    = 6'd35;
    localparam logic [SELW-1:0] OP_AND   = 6'd36;

    logic [SELW-1:0] sel;
    logic            hit;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] shl;
    logic [XLEN-1:0] shr_l;
    logic [XLEN-1:0] shr_a;
    logic [4:0]      shamt;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] alu_q;

    // Scanning downward leaves the lowest set bit in sel, so a malformed
    // multi-hot vector resolves to its lowest-index opcode.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NINSTR - 1; i >= 0; i--) begin
            if (instructions[i]) begin
                sel = SELW'(i);
                hit = 1'b1;
            end
        end
    end

    assign shamt = v2[4:0];
    assign sum   = v1 + v2;
    assign diff  = v1 - v2;
    assign link  = v1 + XLEN'(4);
    assign shl   = v1 << shamt;
    assign shr_l = v1 >> shamt;
    assign shr_a = $signed(v1) >>> shamt;
    assign eq    = (v1 == v2);
    assign lt_s  = ($signed(v1) < $signed(v2));
    assign lt_u  = (v1 < v2);

    always_comb begin
        alu_d = '0;
        if (hit) begin
            case (sel)
                OP_LUI:                                   alu_d = v2;
                OP_AUIPC, OP_LB, OP_LH, OP_LW, OP_LBU,
                OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADDI,
                OP_ADD:                                   alu_d = sum;
                OP_JAL, OP_JALR:                          alu_d = link;
                OP_BEQ:                                   alu_d = XLEN'(eq);
                OP_BNE:                                   alu_d = XLEN'(!eq);
                OP_BLT, OP_SLTI, OP_SLT:                  alu_d = XLEN'(lt_s);
                OP_BGE:                                   alu_d = XLEN'(!lt_s);
                OP_BLTU, OP_SLTIU, OP_SLTU:               alu_d = XLEN'(lt_u);
                OP_BGEU:                                  alu_d = XLEN'(!lt_u);
                OP_SUB:                                   alu_d = diff;
                OP_XORI, OP_XOR:                          alu_d = v1 ^ v2;
                OP_ORI, OP_OR:                            alu_d = v1 | v2;
                OP_ANDI, OP_AND:                          alu_d = v1 & v2;
                OP_SLLI, OP_SLL:                          alu_d = shl;
                OP_SRLI, OP_SRL:                          alu_d = shr_l;
                OP_SRAI, OP_SRA:                          alu_d = shr_a;
                default:                                  alu_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q <= '0;
        end else begin
            alu_q <= alu_d;
        end
    end

    assign ALUoutput = alu_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard testbench for alu with directed and random stimulus

module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [36:0] instructions;
    logic [31:0] ALUoutput;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    alu #(.XLEN(32), .NINSTR(37)) dut (
        .clk          (clk),
        .rst          (rst),
        .v1           (v1),
        .v2           (v2),
        .instructions (instructions),
        .ALUoutput    (ALUoutput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model written from the opcode rules with plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [36:0] ins, input logic [31:0] a,
                                              input logic [31:0] b);
        int          op = -1;
        longint      ua = longint'(a);
        longint      ub = longint'(b);
        longint      m  = 64'h1_0000_0000;
        int          sa = int'(a);
        int          sb = int'(b);
        longint      p2;
        longint      sl;
        int          sh;
        for (int i = 36; i >= 0; i--) if (ins[i]) op = i;
        sh = int'(ub % 32);
        p2 = longint'(1) << sh;
        sl = longint'(sa);
        case (op) inside
            0:                return b;
            1, [10:18], 27:   return 32'((ua + ub) % m);
            2, 3:             return 32'((ua + 4) % m);
            4:                return 32'(a == b);
            5:                return 32'(a != b);
            6, 19, 30:        return 32'(sa < sb);
            7:                return 32'(sa >= sb);
            8, 20, 31:        return 32'(ua < ub);
            9:                return 32'(ua >= ub);
            28:               return 32'((ua - ub + m) % m);
            21, 32:           return a ^ b;
            22, 35:           return a | b;
            23, 36:           return a & b;
            24, 29:           return 32'((ua * p2) % m);
            25, 33:           return 32'(ua / p2);
            26, 34:           return (sl >= 0) ? 32'(sl / p2) : 32'((sl - (p2 - 1)) / p2);
            default:          return 32'd0;
        endcase
    endfunction

    function automatic logic [36:0] oh(input int idx);
        logic [36:0] one = 37'd1;
        return one << idx;
    endfunction

    task automatic issue(input string name, input logic [36:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        instructions = ins;
        v1 = a;
        v2 = b;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: the result registered at each edge answers the oldest outstanding request.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, ALUoutput, e.exp);
        end
    end

    initial begin
        logic [36:0] rins;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          waited;

        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        v1           = '0;
        v2           = '0;
        instructions = '0;
        #1;
        check("reset_state", ALUoutput, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        issue("pre_reset_lui", oh(0), 32'd5, 32'd9, 32'd9);

        // Asynchronous reset mid-cycle, away from any clock edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_clear", ALUoutput, 32'd0);
        @(posedge clk);
        #1;
        check("reset_hold", ALUoutput, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_no_edge", ALUoutput, 32'd0);

        issue("lui",   oh(0), 32'd5, 32'd4, 32'd4);
        issue("auipc", oh(1), 32'd5, 32'd4, 32'd9);
        issue("jal",   oh(2), 32'd5, 32'd4, 32'd9);
        issue("jalr",  oh(3), 32'd5, 32'd4, 32'd9);
        issue("beq",   oh(4), 32'd5, 32'd4, 32'd0);
        issue("bne",   oh(5), 32'd5, 32'd4, 32'd1);
        issue("blt",   oh(6), 32'd5, 32'd4, 32'd0);
        issue("bge",   oh(7), 32'd5, 32'd4, 32'd1);
        issue("bltu",  oh(8), 32'd5, 32'd4, 32'd0);
        issue("bgeu",  oh(9), 32'd5, 32'd4, 32'd1);
        issue("blt_neg",  oh(6), 32'hFFFF_FFFF, 32'd1, 32'd1);
        issue("bltu_big", oh(8), 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("bge_neg",  oh(7), 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("bgeu_big", oh(9), 32'hFFFF_FFFF, 32'd1, 32'd1);
        issue("add", oh(27), 32'd5, 32'd4, 32'd9);
        issue("sub", oh(28), 32'd5, 32'd4, 32'd1);
        issue("xor", oh(32), 32'd5, 32'd4, 32'd1);
        issue("or",  oh(35), 32'd5, 32'd4, 32'd5);
        issue("and", oh(36), 32'd5, 32'd4, 32'd4);
        issue("sll", oh(29), 32'd5, 32'd4, 32'd80);
        issue("srl", oh(33), 32'd5, 32'd4, 32'd0);
        issue("sub_wrap",  oh(28), 32'd0, 32'd1, 32'hFFFF_FFFF);
        issue("add_carry", oh(27), 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue("sra_shamt", oh(34), 32'h8000_0000, 32'h21, 32'hC000_0000);
        issue("srl_shamt", oh(33), 32'h8000_0000, 32'h21, 32'h4000_0000);
        issue("sll_shamt", oh(29), 32'h8000_0000, 32'h21, 32'h0000_0000);
        issue("srai_zero", oh(26), 32'h8765_4321, 32'h20, 32'h8765_4321);
        issue("none_set",  37'd0, 32'd5, 32'd4, 32'd0);
        issue("multi_hot", oh(27) | oh(28), 32'd5, 32'd4, 32'd9);

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      rins = 37'd0;
            else if (sel <= 2) rins = {5'($urandom), $urandom};
            else               rins = oh(int'($urandom_range(0, 36)));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            issue("random", rins, ra, rb, ref_model(rins, ra, rb));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
